merge_sorter_sequencer: RTL and testbench
=========================================

// Module: merge_sorter_sequencer
// PURPOSE
//  Parametrised control sequencer for the merge sorter datapath. Splits an incoming run of data_length
//  beats into CHUNK_SIZE chunks (last one partial) for the batcher network and counts the sorted stream
//  back, flagging its final beat. Then schedules the log2 merge passes (run length doubling) and reports done.
//  Sits between the AXI-stream input front-end, the batcher sort network and the merge engine.
// PARAMETERS
//  MAX_SORT_LENGTH  256  max beats per sort; power of two
//  CHUNK_SIZE       8    batcher chunk size; power of two, 2..MAX_SORT_LENGTH
//  LW = $clog2(MAX_SORT_LENGTH+1), CW = $clog2(MAX_SORT_LENGTH/CHUNK_SIZE+1)  (derived, not overridable)
// PORTS
//  clock            in   1    system clock
//  reset            in   1    async active-high reset
//  start            in   1    begin a sort of data_length beats (accepted in IDLE only)
//  abort            in   1    sync abort; return to IDLE, no done
//  data_length      in   LW   beats to sort; sampled on accepted start
//  in_valid         in   1    one input beat accepted by the batcher this cycle
//  sorted_valid     in   1    one batcher output beat this cycle
//  merge_done       in   1    merge engine finished current pass
//  busy             out  1    high from accepted start until done cycle inclusive
//  n_chunks         out  CW   latched chunk count = ceil(len/CHUNK_SIZE)
//  chunk_size       out  LW   size of chunk currently being loaded (CHUNK_SIZE or remainder)
//  chunk_last       out  1    in_valid beat closes the current chunk (comb.)
//  sorted_last      out  1    sorted_valid beat is the last of the stream (comb., tlast)
//  merge_start      out  1    1-cycle pulse: start a merge pass
//  run_length       out  LW   sorted run length for current pass (CHUNK_SIZE << pass)
//  done             out  1    1-cycle completion pulse
//  length_error     out  1    1-cycle pulse with done when data_length > MAX_SORT_LENGTH
// BEHAVIOUR
//  Reset: state IDLE; every output and counter 0.
//  FSM: IDLE -> LOAD -> DRAIN -> MERGE_ISSUE <-> MERGE_WAIT -> DONE -> IDLE.
//  IDLE: on start latch len, n_full=len/CHUNK_SIZE, rem=len%CHUNK_SIZE, n_chunks=n_full+(rem!=0); busy<=1.
//   len==0 or len>MAX -> DONE directly (length_error pulses with done if len>MAX). in_valid/sorted_valid ignored.
//  LOAD: beat_cnt counts in_valid within chunk, chunk_idx counts chunks. chunk_size = rem when
//   chunk_idx==n_full and rem!=0, else CHUNK_SIZE (rem==0 never yields a zero-size chunk).
//   chunk_last = in_valid & beat_cnt==chunk_size-1; then beat_cnt<=0, chunk_idx++.
//   Closing the last chunk -> DRAIN. in_valid after that is ignored.
//  out_cnt counts sorted_valid in LOAD and DRAIN (batcher may emit before loading ends).
//   sorted_last = sorted_valid & busy & out_cnt==len-1. out_cnt==len in DRAIN: n_chunks==1 -> DONE,
//   else run_length<=CHUNK_SIZE, -> MERGE_ISSUE. Beats beyond len ignored.
//  MERGE_ISSUE: merge_start=1 for exactly one cycle -> MERGE_WAIT. run_length stable through the pass.
//  MERGE_WAIT: on merge_done run_length<<=1; new run_length >= len -> DONE else -> MERGE_ISSUE.
//   Pass count = ceil(log2(n_chunks)). merge_done in any other state ignored.
//  DONE: done=1 one cycle, busy still 1 -> IDLE (busy 0 next cycle). Next start accepted in IDLE only.
//  start while busy ignored. abort has priority over every event except reset: IDLE next cycle,
//   counters cleared, no done, no merge_start that cycle.
//  Widths: run_length shift computed in LW+1 bits, no wrap at MAX_SORT_LENGTH.
//  Latency: start->first LOAD cycle 1; last sorted beat->merge_start 2 cycles; merge_done->next
//   merge_start 2 cycles; merge_done(final)->done 1 cycle.
// STRUCTURE
//  merge_sorter_pkg: state enum (IDLE, LOAD, DRAIN, MERGE_ISSUE, MERGE_WAIT, DONE), LW/CW width functions.
//  One sub-module: merge_pass_scheduler (run_length doubling, merge_start/merge_done handshake).
//  Chunking and drain counters stay in the top.
// TESTING
//  len=20: chunk_size 8,8,4; chunk_last on beats 8,16,20; sorted_last on 20th; passes run 8,16; done.
//  len=16: n_chunks=2, no partial chunk; one pass run 8; done 1 cycle after merge_done.
//  len=5: single chunk size 5; no merge_start; done 1 cycle after out_cnt reaches 5.
//  len=0 and len=300: done pulse within 2 cycles; length_error only for 300; no chunk_last.
//  len=256: 32 chunks; 5 passes run 8..128; start pulsed mid-sort ignored.
//  reset mid-MERGE_WAIT and abort mid-LOAD: outputs 0 immediately/next cycle, no done; new start works.

Source files
------------

// File: rtl/merge_sorter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : merge_sorter_pkg                                           |
// | Description : Shared state encoding and width helpers for the merge      |
// |               sorter sequencer and its merge pass scheduler.             |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package merge_sorter_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE        = 3'd0;
  localparam state_t S_LOAD        = 3'd1;
  localparam state_t S_DRAIN       = 3'd2;
  localparam state_t S_MERGE_ISSUE = 3'd3;
  localparam state_t S_MERGE_WAIT  = 3'd4;
  localparam state_t S_DONE        = 3'd5;

  // Width able to hold every length 0..max_len inclusive.
  function automatic int calc_lw(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Width able to hold every chunk count 0..max_len/chunk inclusive.
  function automatic int calc_cw(input int max_len, input int chunk);
    return $clog2(max_len / chunk + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/merge_pass_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : merge_pass_scheduler                                       |
// | Description : Owns the sorted run length and the merge_start/merge_done  |
// |               handshake. Doubles the run length after every pass and     |
// |               flags the pass whose doubled length covers the sort.       |
// | Ports       : clock_i/reset_i, abort_i, clear_i (zero run length),       |
// |               init_i (load first run length), issue_i/wait_i (sequencer  |
// |               state), merge_done_i, len_i -> merge_start_o,              |
// |               run_length_o, pass_next_o, pass_final_o                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module merge_pass_scheduler #(
  parameter int LW         = 9,
  parameter int CHUNK_SIZE = 8
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          abort_i,
  input  logic          clear_i,
  input  logic          init_i,
  input  logic          issue_i,
  input  logic          wait_i,
  input  logic          merge_done_i,
  input  logic [LW-1:0] len_i,
  output logic          merge_start_o,
  output logic [LW-1:0] run_length_o,
  output logic          pass_next_o,
  output logic          pass_final_o
);

  logic [LW-1:0] run_length_q, run_length_d;
  logic          merge_start_q, merge_start_d;
  logic [LW:0]   w_run_next;
  logic          w_step;

  // One extra bit so the doubled length is never wrapped before comparing.
  assign w_run_next = {1'b0, run_length_q} << 1;
  assign w_step     = wait_i & merge_done_i & ~abort_i;

  assign pass_final_o = w_step & (w_run_next >= {1'b0, len_i});
  assign pass_next_o  = w_step & ~pass_final_o;

  // The pulse is registered from the issue cycle so that both the drain
  // exit and a pass completion reach merge_start two cycles later.
  assign merge_start_o = merge_start_q & ~abort_i;
  assign run_length_o  = run_length_q;

  always_comb begin
    run_length_d  = run_length_q;
    merge_start_d = issue_i & ~abort_i;
    if (abort_i || clear_i) begin
      run_length_d = '0;
    end else if (init_i) begin
      run_length_d = LW'(CHUNK_SIZE);
    end else if (w_step) begin
      run_length_d = w_run_next[LW-1:0];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      run_length_q  <= '0;
      merge_start_q <= 1'b0;
    end else begin
      run_length_q  <= run_length_d;
      merge_start_q <= merge_start_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/merge_sorter_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : merge_sorter_sequencer                                     |
// | Description : Control sequencer for the merge sorter. Splits a run into  |
// |               CHUNK_SIZE chunks for the batcher, counts the sorted       |
// |               stream back (tlast on its final beat), then schedules the  |
// |               log2 merge passes and pulses done.                         |
// | Ports       : clock_i, reset_i (async), start_i, abort_i, data_length_i, |
// |               in_valid_i, sorted_valid_i, merge_done_i -> busy_o,        |
// |               n_chunks_o, chunk_size_o, chunk_last_o, sorted_last_o,     |
// |               merge_start_o, run_length_o, done_o, length_error_o        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module merge_sorter_sequencer
  import merge_sorter_pkg::*;
#(
  parameter  int MAX_SORT_LENGTH = 256,
  parameter  int CHUNK_SIZE      = 8,
  localparam int LW              = calc_lw(MAX_SORT_LENGTH),
  localparam int CW              = calc_cw(MAX_SORT_LENGTH, CHUNK_SIZE)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [LW-1:0] data_length_i,
  input  logic          in_valid_i,
  input  logic          sorted_valid_i,
  input  logic          merge_done_i,
  output logic          busy_o,
  output logic [CW-1:0] n_chunks_o,
  output logic [LW-1:0] chunk_size_o,
  output logic          chunk_last_o,
  output logic          sorted_last_o,
  output logic          merge_start_o,
  output logic [LW-1:0] run_length_o,
  output logic          done_o,
  output logic          length_error_o
);

  localparam int            C_CSH   = $clog2(CHUNK_SIZE);
  localparam logic [LW-1:0] C_CHUNK = LW'(CHUNK_SIZE);
  localparam logic [LW-1:0] C_MAX   = LW'(MAX_SORT_LENGTH);

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d, rem_q, rem_d;
  logic [LW-1:0] beat_cnt_q, beat_cnt_d, out_cnt_q, out_cnt_d;
  logic [CW-1:0] n_full_q, n_full_d, n_chunks_q, n_chunks_d;
  logic [CW-1:0] chunk_idx_q, chunk_idx_d;
  logic          err_q, err_d;

  logic [CW-1:0] w_len_full;
  logic [LW-1:0] w_len_rem, w_cur_chunk;
  logic          w_len_bad, w_start, w_chunk_last, w_last_chunk;
  logic          w_sorted_take, w_sorted_last, w_drain_done, w_done;
  logic          w_pass_next, w_pass_final;

  assign w_len_full = CW'(data_length_i >> C_CSH);
  assign w_len_rem  = data_length_i & LW'(CHUNK_SIZE - 1);
  assign w_len_bad  = (data_length_i > C_MAX);
  assign w_start    = (state_q == S_IDLE) & start_i & ~abort_i;

  // Only the chunk at index n_full can be partial, and only if rem != 0.
  assign w_cur_chunk  = (state_q != S_LOAD) ? '0 :
                        ((chunk_idx_q == n_full_q) && (rem_q != '0)) ? rem_q : C_CHUNK;
  assign w_chunk_last = (state_q == S_LOAD) & in_valid_i & (beat_cnt_q == w_cur_chunk - LW'(1));
  assign w_last_chunk = w_chunk_last & (chunk_idx_q == n_chunks_q - CW'(1));

  // The batcher may emit while loading is still in progress.
  assign w_sorted_take = ((state_q == S_LOAD) || (state_q == S_DRAIN)) &
                         sorted_valid_i & (out_cnt_q != len_q);
  assign w_sorted_last = w_sorted_take & (out_cnt_q == len_q - LW'(1));
  // Counting the closing beat itself keeps last-beat -> merge_start at two cycles.
  assign w_drain_done  = (state_q == S_DRAIN) & ((out_cnt_q == len_q) | w_sorted_last);

  assign w_done         = (state_q == S_DONE) & ~abort_i;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = w_done;
  assign length_error_o = w_done & err_q;
  assign n_chunks_o     = n_chunks_q;
  assign chunk_size_o   = w_cur_chunk;
  assign chunk_last_o   = w_chunk_last & ~abort_i;
  assign sorted_last_o  = w_sorted_last & ~abort_i;

  merge_pass_scheduler #(
    .LW         (LW),
    .CHUNK_SIZE (CHUNK_SIZE)
  ) u_sched (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .abort_i      (abort_i),
    .clear_i      (w_start),
    .init_i       (w_drain_done & (n_chunks_q != CW'(1))),
    .issue_i      (state_q == S_MERGE_ISSUE),
    .wait_i       (state_q == S_MERGE_WAIT),
    .merge_done_i (merge_done_i),
    .len_i        (len_q),
    .merge_start_o(merge_start_o),
    .run_length_o (run_length_o),
    .pass_next_o  (w_pass_next),
    .pass_final_o (w_pass_final)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rem_d       = rem_q;
    n_full_d    = n_full_q;
    n_chunks_d  = n_chunks_q;
    beat_cnt_d  = beat_cnt_q;
    chunk_idx_d = chunk_idx_q;
    out_cnt_d   = out_cnt_q;
    err_d       = err_q;
    if (abort_i) begin
      state_d     = S_IDLE;
      len_d       = '0;
      rem_d       = '0;
      n_full_d    = '0;
      n_chunks_d  = '0;
      beat_cnt_d  = '0;
      chunk_idx_d = '0;
      out_cnt_d   = '0;
      err_d       = 1'b0;
    end else begin
      if (w_sorted_take) begin
        out_cnt_d = out_cnt_q + LW'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            len_d       = data_length_i;
            err_d       = w_len_bad;
            beat_cnt_d  = '0;
            chunk_idx_d = '0;
            out_cnt_d   = '0;
            if (w_len_bad || (data_length_i == '0)) begin
              // Nothing sensible to chunk: report straight away.
              rem_d      = '0;
              n_full_d   = '0;
              n_chunks_d = '0;
              state_d    = S_DONE;
            end else begin
              rem_d      = w_len_rem;
              n_full_d   = w_len_full;
              n_chunks_d = w_len_full + CW'(w_len_rem != '0);
              state_d    = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_chunk_last) begin
            beat_cnt_d  = '0;
            chunk_idx_d = chunk_idx_q + CW'(1);
            if (w_last_chunk) begin
              state_d = S_DRAIN;
            end
          end else if (in_valid_i) begin
            beat_cnt_d = beat_cnt_q + LW'(1);
          end
        end
        S_DRAIN: begin
          if (w_drain_done) begin
            state_d = (n_chunks_q == CW'(1)) ? S_DONE : S_MERGE_ISSUE;
          end
        end
        S_MERGE_ISSUE: state_d = S_MERGE_WAIT;
        S_MERGE_WAIT: begin
          if (w_pass_final) begin
            state_d = S_DONE;
          end else if (w_pass_next) begin
            state_d = S_MERGE_ISSUE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      rem_q       <= '0;
      n_full_q    <= '0;
      n_chunks_q  <= '0;
      beat_cnt_q  <= '0;
      chunk_idx_q <= '0;
      out_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      n_full_q    <= n_full_d;
      n_chunks_q  <= n_chunks_d;
      beat_cnt_q  <= beat_cnt_d;
      chunk_idx_q <= chunk_idx_d;
      out_cnt_q   <= out_cnt_d;
      err_q       <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_merge_sorter_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_merge_sorter_sequencer                                  |
// | Description : Directed self-checking bench for merge_sorter_sequencer    |
// |               (MAX_SORT_LENGTH=256, CHUNK_SIZE=8).                       |
// | Ports       : none                                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_merge_sorter_sequencer;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [8:0] data_length_i = '0;
  logic       in_valid_i = 1'b0;
  logic       sorted_valid_i = 1'b0;
  logic       merge_done_i = 1'b0;
  logic       busy_o;
  logic [5:0] n_chunks_o;
  logic [8:0] chunk_size_o;
  logic       chunk_last_o;
  logic       sorted_last_o;
  logic       merge_start_o;
  logic [8:0] run_length_o;
  logic       done_o;
  logic       length_error_o;

  int checks = 0;
  int errors = 0;

  merge_sorter_sequencer #(
    .MAX_SORT_LENGTH(256),
    .CHUNK_SIZE     (8)
  ) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .data_length_i (data_length_i),
    .in_valid_i    (in_valid_i),
    .sorted_valid_i(sorted_valid_i),
    .merge_done_i  (merge_done_i),
    .busy_o        (busy_o),
    .n_chunks_o    (n_chunks_o),
    .chunk_size_o  (chunk_size_o),
    .chunk_last_o  (chunk_last_o),
    .sorted_last_o (sorted_last_o),
    .merge_start_o (merge_start_o),
    .run_length_o  (run_length_o),
    .done_o        (done_o),
    .length_error_o(length_error_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_sort(input int len, input int exp_chunks);
    start_i       = 1'b1;
    data_length_i = 9'(len);
    tick();
    start_i = 1'b0;
    #1;
    chk("busy_start", busy_o, 1);
    chk("n_chunks", n_chunks_o, exp_chunks);
  endtask

  // Feeds len input beats; optionally pulses start at beat start_at (must be ignored).
  task automatic load(input int len, input int start_at);
    for (int b = 1; b <= len; b++) begin
      in_valid_i = 1'b1;
      start_i    = (b == start_at);
      if (b == start_at) data_length_i = 9'd5;
      #1;
      chk("chunk_size", chunk_size_o, ((b - 1) / 8 < len / 8) ? 8 : len % 8);
      chk("chunk_last", chunk_last_o, ((b % 8) == 0) || (b == len));
      tick();
    end
    in_valid_i = 1'b0;
    start_i    = 1'b0;
  endtask

  task automatic drain(input int first, input int len);
    for (int s = first; s <= len; s++) begin
      sorted_valid_i = 1'b1;
      #1;
      chk("sorted_last", sorted_last_o, s == len);
      tick();
    end
    sorted_valid_i = 1'b0;
  endtask

  // Entered in the MERGE_ISSUE cycle of the first pass.
  task automatic merge_passes(input int npass);
    for (int p = 0; p < npass; p++) begin
      #1;
      chk("ms_issue", merge_start_o, 0);
      chk("rl_issue", run_length_o, 8 << p);
      tick();
      #1;
      chk("ms_pulse", merge_start_o, 1);
      chk("rl_pass", run_length_o, 8 << p);
      tick();
      merge_done_i = 1'b1;
      #1;
      chk("ms_wait", merge_start_o, 0);
      chk("done_early", done_o, 0);
      tick();
      merge_done_i = 1'b0;
    end
    #1;
    chk("done", done_o, 1);
    chk("busy_done", busy_o, 1);
    chk("lenerr_done", length_error_o, 0);
    chk("rl_final", run_length_o, 8 << npass);
    tick();
    #1;
    chk("busy_after", busy_o, 0);
    chk("done_after", done_o, 0);
  endtask

  task automatic single_chunk_end();
    #1;
    chk("done_single", done_o, 1);
    chk("ms_single", merge_start_o, 0);
    tick();
    #1;
    chk("busy_single", busy_o, 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_nchunks", n_chunks_o, 0);
    chk("rst_csize", chunk_size_o, 0);
    chk("rst_rl", run_length_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ms", merge_start_o, 0);
    reset_i = 1'b0;
    tick();

    // len=20: chunks 8,8,4; sorted beats overlap loading from beat 9; passes 8,16
    start_sort(20, 3);
    for (int b = 1; b <= 20; b++) begin
      in_valid_i     = 1'b1;
      sorted_valid_i = (b > 8);
      #1;
      chk("c20_size", chunk_size_o, (b <= 16) ? 8 : 4);
      chk("c20_last", chunk_last_o, (b == 8) || (b == 16) || (b == 20));
      chk("c20_slast", sorted_last_o, 0);
      tick();
    end
    in_valid_i = 1'b0;
    drain(13, 20);
    merge_passes(2);

    // len=16: two full chunks, one pass
    start_sort(16, 2);
    load(16, 0);
    drain(1, 16);
    merge_passes(1);

    // len=5: single partial chunk, no merge pass
    start_sort(5, 1);
    load(5, 0);
    drain(1, 5);
    single_chunk_end();

    // len=0: immediate done, no error, in_valid ignored
    start_sort(0, 0);
    in_valid_i = 1'b1;
    #1;
    chk("z_done", done_o, 1);
    chk("z_err", length_error_o, 0);
    chk("z_clast", chunk_last_o, 0);
    tick();
    in_valid_i = 1'b0;
    #1;
    chk("z_busy", busy_o, 0);

    // len=300: immediate done with length_error
    start_sort(300, 0);
    #1;
    chk("big_done", done_o, 1);
    chk("big_err", length_error_o, 1);
    tick();
    #1;
    chk("big_busy", busy_o, 0);
    chk("big_err_after", length_error_o, 0);

    // len=256: 32 chunks, start pulsed mid-load ignored, five passes 8..128
    start_sort(256, 32);
    load(256, 100);
    #1;
    chk("n256_kept", n_chunks_o, 32);
    drain(1, 256);
    merge_passes(5);

    // abort mid-LOAD, then a fresh sort
    start_sort(20, 3);
    for (int b = 1; b <= 5; b++) begin
      in_valid_i = 1'b1;
      tick();
    end
    abort_i = 1'b1;
    #1;
    chk("ab_done", done_o, 0);
    tick();
    abort_i    = 1'b0;
    in_valid_i = 1'b0;
    #1;
    chk("ab_busy", busy_o, 0);
    chk("ab_csize", chunk_size_o, 0);
    chk("ab_nchunks", n_chunks_o, 0);
    start_sort(5, 1);
    load(5, 0);
    drain(1, 5);
    single_chunk_end();

    // reset mid-MERGE_WAIT, then a fresh sort
    start_sort(16, 2);
    load(16, 0);
    drain(1, 16);
    tick();
    #1;
    chk("rw_ms", merge_start_o, 1);
    reset_i = 1'b1;
    #1;
    chk("rw_busy", busy_o, 0);
    chk("rw_ms0", merge_start_o, 0);
    chk("rw_rl", run_length_o, 0);
    chk("rw_nchunks", n_chunks_o, 0);
    tick();
    reset_i      = 1'b0;
    merge_done_i = 1'b1;
    #1;
    chk("rw_nodone", done_o, 0);
    tick();
    merge_done_i = 1'b0;
    #1;
    chk("rw_nodone2", done_o, 0);
    chk("rw_noms", merge_start_o, 0);
    start_sort(16, 2);
    load(16, 0);
    drain(1, 16);
    merge_passes(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
